// File: rtl/mem_lsu.sv
// Memory stage between EX and WB: forwards writeback fields and runs loads/stores
// over a request/grant/response bus, holding the pipeline while an access is in flight.
module mem_lsu #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [XLEN-1:0]       ex_wdata,
  input  logic                  ex_we,
  input  logic                  ex_csr_we,
  input  logic [CSR_ADDR_W-1:0] ex_csr_waddr,
  input  logic [XLEN-1:0]       ex_csr_wdata,
  input  logic                  ex_mem_re,
  input  logic                  ex_mem_we,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_unsigned,
  input  logic [XLEN-1:0]       ex_mem_addr,
  input  logic [XLEN-1:0]       ex_mem_sdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [XLEN-1:0]       bus_addr,
  output logic [XLEN-1:0]       bus_wdata,
  output logic [XLEN/8-1:0]     bus_wstrb,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [XLEN-1:0]       bus_rdata,
  input  logic                  bus_err,
  output logic                  mem_valid,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic                  mem_we,
  output logic                  mem_csr_we,
  output logic [CSR_ADDR_W-1:0] mem_csr_waddr,
  output logic [XLEN-1:0]       mem_csr_wdata,
  output logic                  mem_exc,
  output logic [3:0]            mem_exc_cause,
  output logic                  stall_req
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                state_q, state_d;
  logic                  bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [XLEN-1:0]       bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]     bus_wstrb_q, bus_wstrb_d;
  logic                  op_load_q, op_load_d, op_uns_q, op_uns_d;
  logic [1:0]            op_size_q, op_size_d;
  logic [OFF_W-1:0]      op_off_q, op_off_d;
  logic [REG_ADDR_W-1:0] op_waddr_q, op_waddr_d;
  logic [XLEN-1:0]       op_wdata_q, op_wdata_d;
  logic                  op_we_q, op_we_d, op_csr_we_q, op_csr_we_d;
  logic [CSR_ADDR_W-1:0] op_csr_waddr_q, op_csr_waddr_d;
  logic [XLEN-1:0]       op_csr_wdata_q, op_csr_wdata_d;
  logic                  mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic                  mem_csr_we_q, mem_csr_we_d, mem_exc_q, mem_exc_d;
  logic [REG_ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
  logic [CSR_ADDR_W-1:0] mem_csr_waddr_q, mem_csr_waddr_d;
  logic [XLEN-1:0]       mem_csr_wdata_q, mem_csr_wdata_d;
  logic [3:0]            mem_exc_cause_q, mem_exc_cause_d;

  logic                  is_mem, misaligned, size_fault, legal;
  logic [OFF_W-1:0]      ex_off;
  logic [STRB_W-1:0]     size_strb;
  logic [XLEN-1:0]       size_dmask, ld_shift, ld_data;

  // Decode of the op currently presented by EX.
  always_comb begin
    is_mem = ex_mem_re | ex_mem_we;
    ex_off = ex_mem_addr[OFF_W-1:0];
    case (ex_mem_size)
      2'd0:    begin misaligned = 1'b0;              size_strb = STRB_W'(8'h01); size_dmask = XLEN'(64'hFF);        end
      2'd1:    begin misaligned = ex_mem_addr[0];    size_strb = STRB_W'(8'h03); size_dmask = XLEN'(64'hFFFF);      end
      2'd2:    begin misaligned = |ex_mem_addr[1:0]; size_strb = STRB_W'(8'h0F); size_dmask = XLEN'(64'hFFFF_FFFF); end
      default: begin misaligned = |ex_mem_addr[2:0]; size_strb = '1;             size_dmask = '1;                   end
    endcase
    size_fault = (ex_mem_size == 2'd3) && (XLEN == 32);
    legal      = ex_valid & is_mem & ~misaligned & ~size_fault;
  end

  assign stall_req = (state_q != IDLE) | legal;

  // Pick the addressed lane out of the read word, then sign or zero extend it.
  always_comb begin
    ld_shift = bus_rdata >> {op_off_q, 3'b000};
    ld_data  = ld_shift;
    case (op_size_q)
      2'd0: begin ld_data = {XLEN{~op_uns_q & ld_shift[7]}};  ld_data[7:0]  = ld_shift[7:0];  end
      2'd1: begin ld_data = {XLEN{~op_uns_q & ld_shift[15]}}; ld_data[15:0] = ld_shift[15:0]; end
      2'd2: begin ld_data = {XLEN{~op_uns_q & ld_shift[31]}}; ld_data[31:0] = ld_shift[31:0]; end
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets a default up front so no path leaves it unassigned and infers a latch.
    state_d         = state_q;
    bus_req_d       = bus_req_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_wdata_d     = bus_wdata_q;
    bus_wstrb_d     = bus_wstrb_q;
    op_load_d       = op_load_q;
    op_uns_d        = op_uns_q;
    op_size_d       = op_size_q;
    op_off_d        = op_off_q;
    op_waddr_d      = op_waddr_q;
    op_wdata_d      = op_wdata_q;
    op_we_d         = op_we_q;
    op_csr_we_d     = op_csr_we_q;
    op_csr_waddr_d  = op_csr_waddr_q;
    op_csr_wdata_d  = op_csr_wdata_q;
    mem_waddr_d     = mem_waddr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_csr_waddr_d = mem_csr_waddr_q;
    mem_csr_wdata_d = mem_csr_wdata_q;
    mem_valid_d     = 1'b0;
    mem_we_d        = 1'b0;
    mem_csr_we_d    = 1'b0;
    mem_exc_d       = 1'b0;
    mem_exc_cause_d = 4'd0;

    case (state_q)
      IDLE: if (ex_valid) begin
        if (legal) begin
          state_d        = REQ;
          bus_req_d      = 1'b1;
          bus_we_d       = ~ex_mem_re;
          bus_addr_d     = ex_mem_addr & ~XLEN'(STRB_W - 1);
          bus_wstrb_d    = ex_mem_re ? '0 : STRB_W'(size_strb << ex_off);
          bus_wdata_d    = (ex_mem_sdata & size_dmask) << {ex_off, 3'b000};
          op_load_d      = ex_mem_re;
          op_uns_d       = ex_mem_unsigned;
          op_size_d      = ex_mem_size;
          op_off_d       = ex_off;
          op_waddr_d     = ex_waddr;
          op_wdata_d     = ex_wdata;
          op_we_d        = ex_we;
          op_csr_we_d    = ex_csr_we;
          op_csr_waddr_d = ex_csr_waddr;
          op_csr_wdata_d = ex_csr_wdata;
        end else begin
          mem_valid_d     = 1'b1;
          mem_waddr_d     = ex_waddr;
          mem_wdata_d     = ex_wdata;
          mem_csr_waddr_d = ex_csr_waddr;
          mem_csr_wdata_d = ex_csr_wdata;
          if (is_mem) begin
            mem_exc_d       = 1'b1;
            mem_exc_cause_d = misaligned ? (ex_mem_re ? 4'd4 : 4'd6) : (ex_mem_re ? 4'd5 : 4'd7);
          end else begin
            mem_we_d     = ex_we;
            mem_csr_we_d = ex_csr_we;
          end
        end
      end
      REQ: if (bus_gnt) begin
        state_d   = RESP;
        bus_req_d = 1'b0;
      end
      RESP: if (bus_rvalid) begin
        state_d         = IDLE;
        mem_valid_d     = 1'b1;
        mem_waddr_d     = op_waddr_q;
        mem_wdata_d     = op_load_q ? ld_data : op_wdata_q;
        mem_csr_waddr_d = op_csr_waddr_q;
        mem_csr_wdata_d = op_csr_wdata_q;
        if (bus_err) begin
          mem_exc_d       = 1'b1;
          mem_exc_cause_d = op_load_q ? 4'd5 : 4'd7;
        end else begin
          mem_we_d     = op_load_q & op_we_q;
          mem_csr_we_d = op_csr_we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      bus_wstrb_q     <= '0;
      op_load_q       <= 1'b0;
      op_uns_q        <= 1'b0;
      op_size_q       <= 2'd0;
      op_off_q        <= '0;
      op_waddr_q      <= '0;
      op_wdata_q      <= '0;
      op_we_q         <= 1'b0;
      op_csr_we_q     <= 1'b0;
      op_csr_waddr_q  <= '0;
      op_csr_wdata_q  <= '0;
      mem_valid_q     <= 1'b0;
      mem_waddr_q     <= '0;
      mem_wdata_q     <= '0;
      mem_we_q        <= 1'b0;
      mem_csr_we_q    <= 1'b0;
      mem_csr_waddr_q <= '0;
      mem_csr_wdata_q <= '0;
      mem_exc_q       <= 1'b0;
      mem_exc_cause_q <= 4'd0;
    end else begin
      state_q         <= state_d;
      bus_req_q       <= bus_req_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_wstrb_q     <= bus_wstrb_d;
      op_load_q       <= op_load_d;
      op_uns_q        <= op_uns_d;
      op_size_q       <= op_size_d;
      op_off_q        <= op_off_d;
      op_waddr_q      <= op_waddr_d;
      op_wdata_q      <= op_wdata_d;
      op_we_q         <= op_we_d;
      op_csr_we_q     <= op_csr_we_d;
      op_csr_waddr_q  <= op_csr_waddr_d;
      op_csr_wdata_q  <= op_csr_wdata_d;
      mem_valid_q     <= mem_valid_d;
      mem_waddr_q     <= mem_waddr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_we_q        <= mem_we_d;
      mem_csr_we_q    <= mem_csr_we_d;
      mem_csr_waddr_q <= mem_csr_waddr_d;
      mem_csr_wdata_q <= mem_csr_wdata_d;
      mem_exc_q       <= mem_exc_d;
      mem_exc_cause_q <= mem_exc_cause_d;
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wstrb     = bus_wstrb_q;
  assign mem_valid     = mem_valid_q;
  assign mem_waddr     = mem_waddr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign mem_csr_we    = mem_csr_we_q;
  assign mem_csr_waddr = mem_csr_waddr_q;
  assign mem_csr_wdata = mem_csr_wdata_q;
  assign mem_exc       = mem_exc_q;
  assign mem_exc_cause = mem_exc_cause_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu (XLEN=32): directed scenarios plus random loads/stores, each acting
// as the bus and comparing against expectations derived from address/size arithmetic.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_we, ex_csr_we, ex_mem_re, ex_mem_we, ex_mem_unsigned;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata, ex_csr_wdata, ex_mem_addr, ex_mem_sdata;
  logic [11:0] ex_csr_waddr;
  logic [1:0]  ex_mem_size;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        mem_valid, mem_we, mem_csr_we, mem_exc, stall_req;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, mem_csr_wdata;
  logic [11:0] mem_csr_waddr;
  logic [3:0]  mem_exc_cause;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic        ld, st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, sdata, wdata, csr_wdata, rdata;
    logic [4:0]  waddr;
    logic        we, csr_we, err;
    logic [11:0] csr_waddr;
    int          gnt_dly, rsp_dly;
  } op_t;

  mem_lsu #(.XLEN(32), .REG_ADDR_W(5), .CSR_ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_we(ex_we),
    .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr), .ex_csr_wdata(ex_csr_wdata),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_err(bus_err),
    .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_csr_we(mem_csr_we), .mem_csr_waddr(mem_csr_waddr), .mem_csr_wdata(mem_csr_wdata),
    .mem_exc(mem_exc), .mem_exc_cause(mem_exc_cause), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_we = 0; ex_csr_we = 0; ex_mem_re = 0; ex_mem_we = 0; ex_mem_unsigned = 0;
    ex_waddr = 0; ex_wdata = 0; ex_csr_wdata = 0; ex_csr_waddr = 0; ex_mem_size = 0;
    ex_mem_addr = 0; ex_mem_sdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = 0;
  endtask

  function automatic op_t blank_op();
    op_t o;
    o.ld = 0; o.st = 0; o.size = 0; o.uns = 0; o.addr = 0; o.sdata = 0; o.wdata = 0;
    o.csr_wdata = 0; o.rdata = 0; o.waddr = 0; o.we = 0; o.csr_we = 0; o.err = 0;
    o.csr_waddr = 0; o.gnt_dly = 0; o.rsp_dly = 0;
    return o;
  endfunction

  // Presents one instruction, plays the bus side, and checks the writeback.
  task automatic run_op(input op_t o, input string tag);
    int          nbytes, off;
    bit          is_ld, is_st, misal, legal;
    logic [63:0] lmask, v;
    logic [31:0] exp_addr, exp_ld, exp_wd, byte_m, exp_wdata;
    logic [3:0]  exp_strb, exp_cause;
    logic        exp_exc, exp_we, exp_csr_we;

    is_ld    = o.ld;
    is_st    = o.st && !o.ld;
    nbytes   = 1 << o.size;
    off      = int'(o.addr % 4);
    misal    = (o.addr % nbytes) != 0;
    legal    = (is_ld || is_st) && !misal && (nbytes <= 4);
    exp_addr = o.addr - (o.addr % 4);
    lmask    = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
    v        = ({32'd0, o.rdata} >> (8 * off)) & lmask;
    if (!o.uns && v[8 * nbytes - 1]) v = v | ~lmask;
    exp_ld   = v[31:0];
    exp_strb = 4'(((1 << nbytes) - 1) << off);
    exp_wd   = 32'(({32'd0, o.sdata} & lmask) << (8 * off));
    for (int b = 0; b < 4; b++) byte_m[8*b +: 8] = {8{exp_strb[b]}};

    if (!(is_ld || is_st)) begin
      exp_exc = 0; exp_cause = 0; exp_we = o.we; exp_csr_we = o.csr_we; exp_wdata = o.wdata;
    end else if (!legal) begin
      exp_exc = 1; exp_cause = misal ? (is_ld ? 4'd4 : 4'd6) : (is_ld ? 4'd5 : 4'd7);
      exp_we = 0; exp_csr_we = 0; exp_wdata = o.wdata;
    end else if (o.err) begin
      exp_exc = 1; exp_cause = is_ld ? 4'd5 : 4'd7; exp_we = 0; exp_csr_we = 0; exp_wdata = exp_ld;
    end else begin
      exp_exc = 0; exp_cause = 0; exp_we = is_ld && o.we; exp_csr_we = o.csr_we; exp_wdata = exp_ld;
    end

    ex_valid = 1; ex_mem_re = o.ld; ex_mem_we = o.st; ex_mem_size = o.size;
    ex_mem_unsigned = o.uns; ex_mem_addr = o.addr; ex_mem_sdata = o.sdata;
    ex_waddr = o.waddr; ex_wdata = o.wdata; ex_we = o.we; ex_csr_we = o.csr_we;
    ex_csr_waddr = o.csr_waddr; ex_csr_wdata = o.csr_wdata;
    #1;
    n_vec++;
    if (stall_req !== legal) begin n_err++; $display("FAIL %s stall_accept: got %b want %b", tag, stall_req, legal); end
    step();
    ex_valid = 0; ex_mem_re = 0; ex_mem_we = 0;

    if (legal) begin
      n_vec++;
      if (bus_req !== 1'b1 || bus_addr !== exp_addr || bus_we !== is_st) begin
        n_err++;
        $display("FAIL %s bus_issue: req=%b addr=%h we=%b want req=1 addr=%h we=%b", tag, bus_req, bus_addr, bus_we, exp_addr, is_st);
      end
      if (is_st) begin
        n_vec++;
        if (bus_wstrb !== exp_strb || (bus_wdata & byte_m) !== exp_wd) begin
          n_err++;
          $display("FAIL %s store_lanes: strb=%b data=%h want strb=%b data=%h", tag, bus_wstrb, bus_wdata & byte_m, exp_strb, exp_wd);
        end
      end
      for (int i = 0; i < o.gnt_dly; i++) begin
        step();
        n_vec++;
        if (bus_req !== 1'b1 || bus_addr !== exp_addr || stall_req !== 1'b1) begin
          n_err++;
          $display("FAIL %s req_hold: req=%b addr=%h stall=%b want 1 %h 1", tag, bus_req, bus_addr, stall_req, exp_addr);
        end
      end
      bus_gnt = 1;
      step();
      bus_gnt = 0;
      n_vec++;
      if (bus_req !== 1'b0 || stall_req !== 1'b1 || mem_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s after_gnt: req=%b stall=%b valid=%b want 0 1 0", tag, bus_req, stall_req, mem_valid);
      end
      for (int i = 0; i < o.rsp_dly; i++) begin
        step();
        n_vec++;
        if (mem_valid !== 1'b0 || stall_req !== 1'b1) begin
          n_err++;
          $display("FAIL %s resp_wait: valid=%b stall=%b want 0 1", tag, mem_valid, stall_req);
        end
      end
      bus_rvalid = 1; bus_rdata = o.rdata; bus_err = o.err;
      step();
      bus_rvalid = 0; bus_err = 0; bus_rdata = $urandom;
    end else begin
      n_vec++;
      if (bus_req !== 1'b0) begin n_err++; $display("FAIL %s no_bus: got req=%b want 0", tag, bus_req); end
    end

    n_vec++;
    if (mem_valid !== 1'b1 || mem_exc !== exp_exc || mem_exc_cause !== exp_cause ||
        mem_we !== exp_we || mem_csr_we !== exp_csr_we || mem_waddr !== o.waddr || stall_req !== 1'b0) begin
      n_err++;
      $display("FAIL %s writeback: valid=%b exc=%b cause=%0d we=%b csr_we=%b waddr=%0d stall=%b want 1 %b %0d %b %b %0d 0",
               tag, mem_valid, mem_exc, mem_exc_cause, mem_we, mem_csr_we, mem_waddr, stall_req,
               exp_exc, exp_cause, exp_we, exp_csr_we, o.waddr);
    end
    if (!exp_exc && !is_st) begin
      n_vec++;
      if (mem_wdata !== exp_wdata) begin n_err++; $display("FAIL %s wdata: got %h want %h", tag, mem_wdata, exp_wdata); end
    end
    if (exp_csr_we) begin
      n_vec++;
      if (mem_csr_waddr !== o.csr_waddr || mem_csr_wdata !== o.csr_wdata) begin
        n_err++;
        $display("FAIL %s csr_fields: got %h/%h want %h/%h", tag, mem_csr_waddr, mem_csr_wdata, o.csr_waddr, o.csr_wdata);
      end
    end
    step();
    n_vec++;
    if (mem_valid !== 1'b0) begin n_err++; $display("FAIL %s valid_pulse: got %b want 0", tag, mem_valid); end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (3) step();
    n_vec++;
    if (mem_valid !== 0 || mem_we !== 0 || mem_csr_we !== 0 || mem_exc !== 0 || mem_exc_cause !== 0 ||
        mem_wdata !== 0 || mem_waddr !== 0 || bus_req !== 0 || stall_req !== 0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b we=%b csr_we=%b exc=%b cause=%0d wdata=%h req=%b stall=%b want all 0",
               mem_valid, mem_we, mem_csr_we, mem_exc, mem_exc_cause, mem_wdata, bus_req, stall_req);
    end
    rst = 0;
    step();
  endtask

  task automatic test_passthrough();
    op_t o = blank_op();
    o.waddr = 5; o.wdata = 32'h1234; o.we = 1; o.csr_we = 1; o.csr_waddr = 12'h305; o.csr_wdata = 32'hCAFE_0001;
    run_op(o, "passthrough");
  endtask

  task automatic test_loads();
    op_t o = blank_op();
    o.ld = 1; o.size = 0; o.addr = 32'h1003; o.rdata = 32'h80FF_FF7F; o.waddr = 9; o.we = 1;
    run_op(o, "lb_signed");
    o.uns = 1;
    run_op(o, "lbu");
    o.uns = 0; o.size = 1; o.addr = 32'h1002; o.rdata = 32'h9ABC_1234;
    run_op(o, "lh_signed");
    o.size = 2; o.addr = 32'h1004; o.rdata = 32'hDEAD_BEEF; o.gnt_dly = 1; o.rsp_dly = 2;
    run_op(o, "lw");
    o.st = 1; o.size = 0; o.addr = 32'h1001; o.rdata = 32'h0000_7F00; o.gnt_dly = 0; o.rsp_dly = 0;
    run_op(o, "re_priority");
  endtask

  task automatic test_store();
    op_t o = blank_op();
    o.st = 1; o.size = 1; o.addr = 32'h2002; o.sdata = 32'hFFFF_ABCD; o.waddr = 3; o.we = 1;
    run_op(o, "sh");
    o.size = 0; o.addr = 32'h2001; o.sdata = 32'h0000_005A;
    run_op(o, "sb");
  endtask

  task automatic test_misaligned();
    op_t o = blank_op();
    o.ld = 1; o.size = 2; o.addr = 32'h3001; o.we = 1; o.waddr = 7;
    run_op(o, "lw_misaligned");
    o.ld = 0; o.st = 1; o.size = 1; o.addr = 32'h3003;
    run_op(o, "sh_misaligned");
    o.ld = 1; o.st = 0; o.size = 3; o.addr = 32'h4000;
    run_op(o, "ld_on_rv32");
  endtask

  task automatic test_delayed_err();
    op_t o = blank_op();
    o.st = 1; o.size = 2; o.addr = 32'h5008; o.sdata = 32'h1122_3344; o.gnt_dly = 3; o.rsp_dly = 1;
    o.err = 1; o.csr_we = 1;
    run_op(o, "store_fault");
    o.st = 0; o.ld = 1; o.we = 1;
    run_op(o, "load_fault");
  endtask

  task automatic test_reset_mid();
    ex_valid = 1; ex_mem_re = 1; ex_mem_size = 2; ex_mem_addr = 32'h6000; ex_we = 1; ex_waddr = 4;
    step();
    ex_valid = 0; ex_mem_re = 0;
    bus_gnt = 1;
    step();
    bus_gnt = 0;
    rst = 1;
    step();
    rst = 0;
    n_vec++;
    if (bus_req !== 0 || mem_valid !== 0 || stall_req !== 0) begin
      n_err++;
      $display("FAIL reset_mid: req=%b valid=%b stall=%b want 0 0 0", bus_req, mem_valid, stall_req);
    end
    bus_rvalid = 1; bus_rdata = 32'h1357_9BDF;
    step();
    bus_rvalid = 0;
    n_vec++;
    if (mem_valid !== 0) begin n_err++; $display("FAIL stray_rvalid: got valid=%b want 0", mem_valid); end
    step();
    n_vec++;
    if (mem_valid !== 0 || stall_req !== 0) begin
      n_err++;
      $display("FAIL stray_after: valid=%b stall=%b want 0 0", mem_valid, stall_req);
    end
  endtask

  task automatic test_random();
    op_t o;
    int  kind;
    for (int n = 0; n < 60; n++) begin
      o = blank_op();
      kind = int'($urandom_range(0, 2));
      o.ld = (kind == 1); o.st = (kind == 2);
      o.size = 2'($urandom_range(0, 3));
      o.uns = 1'($urandom);
      o.addr = $urandom;
      if ($urandom_range(0, 3) != 0) o.addr = o.addr & ~((32'd1 << o.size) - 32'd1);
      o.sdata = $urandom; o.wdata = $urandom; o.rdata = $urandom;
      o.waddr = 5'($urandom); o.we = 1'($urandom); o.csr_we = 1'($urandom);
      o.csr_waddr = 12'($urandom); o.csr_wdata = $urandom;
      o.gnt_dly = int'($urandom_range(0, 3)); o.rsp_dly = int'($urandom_range(0, 3));
      o.err = ($urandom_range(0, 7) == 0);
      run_op(o, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_store();
    test_misaligned();
    test_delayed_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
